// File: rtl/video_stream_monitor_pkg.sv
// Shared definitions for the video stream monitor.
//   - Bit positions of the sticky error vector and its width.
//   - Width of the {dv,hs,vs} sync bundle.
//   - Monitor FSM state encoding.
package video_mon_pkg;

  localparam int ERR_SYNC   = 0;
  localparam int ERR_WIDTH  = 1;
  localparam int ERR_HEIGHT = 2;
  localparam int ERR_LEND   = 3;
  localparam int ERR_PROTO  = 4;
  localparam int ERR_W      = 5;

  localparam int SYNC_W     = 3;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,  // delay line still holds post-reset zeros
    S_SYNC = 2'd1,  // waiting for the first output frame start
    S_RUN  = 2'd2   // frame-aligned, all checks active
  } state_e;

endpackage

// File: rtl/video_stream_monitor_if.sv
// Sync-signal bundle observed around one pixel-pipeline stage.
//   dv_i/hs_i/vs_i : stage input data valid / hsync / vsync
//   dv_o/hs_o/vs_o : stage output data valid / hsync / vsync
//   line_end_o     : stage output line-end strobe
// master drives the bundle (the stage or a stimulus source); slave only
// observes it (the monitor).
interface video_stream_monitor_if;

  logic dv_i;
  logic hs_i;
  logic vs_i;
  logic dv_o;
  logic hs_o;
  logic vs_o;
  logic line_end_o;

  modport master (
    output dv_i, hs_i, vs_i, dv_o, hs_o, vs_o, line_end_o
  );

  modport slave (
    input dv_i, hs_i, vs_i, dv_o, hs_o, vs_o, line_end_o
  );

endinterface

// File: rtl/video_stream_monitor_sync_delay_line.sv
// WIDTH x DEPTH shift register used to align the stage input sync bits
// with the stage output.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : WIDTH-bit sample entering the line
//   q_o        : sample that entered DEPTH cycles earlier (0 after reset)
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its neighbour's old value and the line really shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is cleared on reset on purpose: the monitor relies
      // on known zeros while the line refills, unlike a data RAM.
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_stream_monitor.sv
// In-line checker for a fixed-latency pixel-pipeline stage.
//   clk, rst_n      : clock, asynchronous active-low reset
//   mon             : observed input/output sync bundle (slave modport)
//   clr_i           : one-cycle pulse clearing the sticky errors
//   err_o           : sticky errors [SYNC, WIDTH, HEIGHT, LEND, PROTO]
//   err_any_o       : OR of err_o, registered alongside it
//   meas_width_o    : dv_o beats of the last completed line
//   meas_height_o   : lines of the last completed frame
//   frame_cnt_o     : vs_o rising edges seen after the fill phase (wraps)
//   frame_ok_o      : pulse after a frame-closing vs_o rise with no error
// All outputs are registered: they react one cycle after the cause.
module video_stream_monitor
  import video_mon_pkg::*;
#(
  parameter int LATENCY  = 4,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int CNT_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  video_stream_monitor_if.slave mon,
  input  logic                  clr_i,
  output logic [ERR_W-1:0]      err_o,
  output logic                  err_any_o,
  output logic [CNT_W-1:0]      meas_width_o,
  output logic [CNT_W-1:0]      meas_height_o,
  output logic [CNT_W-1:0]      frame_cnt_o,
  output logic                  frame_ok_o
);

  localparam int FILL_W = $clog2(LATENCY + 1);

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;

  logic [SYNC_W-1:0] sync_in, sync_out, sync_dly;
  logic              dv_o_q, vs_o_q;
  logic              dv_fall, vs_rise;
  logic              chk_en, run_en;

  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]  meas_width_q, meas_width_d;
  logic [CNT_W-1:0]  meas_height_q, meas_height_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic [ERR_W-1:0]  err_ev;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              err_any_q;
  logic              frame_err_q, frame_err_d;
  logic              frame_ok_q, frame_ok_d;

  // Input sync bits delayed by the stage latency for alignment checking.
  assign sync_in  = {mon.dv_i, mon.hs_i, mon.vs_i};
  assign sync_out = {mon.dv_o, mon.hs_o, mon.vs_o};

  sync_delay_line #(
    .WIDTH (SYNC_W),
    .DEPTH (LATENCY)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sync_in),
    .q_o   (sync_dly)
  );

  assign dv_fall = dv_o_q && !mon.dv_o;
  assign vs_rise = mon.vs_o && !vs_o_q;
  assign chk_en  = (state_q != S_FILL);
  assign run_en  = (state_q == S_RUN);

  // FSM: hold off checks until the delay line holds real samples, then
  // wait for a frame start before trusting line/frame counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    unique case (state_q)
      S_FILL: begin
        if (fill_cnt_q == FILL_W'(LATENCY - 1)) state_d = S_SYNC;
        else fill_cnt_d = fill_cnt_q + FILL_W'(1);
      end
      S_SYNC:  if (vs_rise) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_FILL;
    endcase
  end

  // Error events of the current cycle.
  always_comb begin
    err_ev = '0;
    if (chk_en) begin
      err_ev[ERR_SYNC]  = (sync_dly != sync_out);
      err_ev[ERR_WIDTH] = dv_fall && (pix_cnt_q != CNT_W'(H_ACTIVE));
      err_ev[ERR_LEND]  = (mon.line_end_o != dv_fall);
      err_ev[ERR_PROTO] = mon.dv_o && (mon.vs_o || mon.hs_o);
    end
    // The first frame start only aligns the line counter, so height is
    // judged only once the monitor has seen a complete frame.
    if (run_en) begin
      err_ev[ERR_HEIGHT] = vs_rise && (line_cnt_q != CNT_W'(V_ACTIVE));
    end
  end

  // Counters, measurements and sticky/frame error bookkeeping.
  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    meas_width_d  = meas_width_q;
    meas_height_d = meas_height_q;
    frame_cnt_d   = frame_cnt_q;

    if (chk_en) begin
      if (dv_fall) begin
        meas_width_d = pix_cnt_q;
        pix_cnt_d    = '0;
      end else if (mon.dv_o && (pix_cnt_q != '1)) begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
      if (vs_rise) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    if (vs_rise && run_en) begin
      meas_height_d = line_cnt_q;
      line_cnt_d    = '0;
    end else if (vs_rise && chk_en) begin
      line_cnt_d = '0;
    end else if (run_en && dv_fall && (line_cnt_q != '1)) begin
      line_cnt_d = line_cnt_q + CNT_W'(1);
    end

    // An event coinciding with clr_i survives the clear.
    err_d = (clr_i ? '0 : err_q) | err_ev;

    // The frame flag covers everything since the previous vs_o rise,
    // including events in the rise cycle itself, and restarts at each rise.
    frame_ok_d  = run_en && vs_rise && !frame_err_q && !(|err_ev);
    frame_err_d = (chk_en && vs_rise) ? 1'b0 : (frame_err_q || (|err_ev));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_o_q        <= 1'b0;
      vs_o_q        <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      meas_width_q  <= '0;
      meas_height_q <= '0;
      frame_cnt_q   <= '0;
      err_q         <= '0;
      err_any_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_ok_q    <= 1'b0;
    end else begin
      dv_o_q        <= mon.dv_o;
      vs_o_q        <= mon.vs_o;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      meas_width_q  <= meas_width_d;
      meas_height_q <= meas_height_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
      err_any_q     <= |err_d;
      frame_err_q   <= frame_err_d;
      frame_ok_q    <= frame_ok_d;
    end
  end

  assign err_o         = err_q;
  assign err_any_o     = err_any_q;
  assign meas_width_o  = meas_width_q;
  assign meas_height_o = meas_height_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign frame_ok_o    = frame_ok_q;

endmodule

// File: doc/video_stream_monitor.md
Name: video_stream_monitor

Overview:
Synthesizable in-line checker for pixel-pipeline stages such as the rgb2y converter. It is placed across a stage with a fixed latency and watches the input sync signals (dv/hs/vs) and the output signals (dv/hs/vs/line_end). It checks input-to-output sync alignment, active line width, frame height, line_end placement and basic protocol rules. Results are sticky error flags plus measurement counters that firmware can read and clear.

Parameters:
LATENCY, 4, expected cycles from stage input to stage output (≥1)
H_ACTIVE, 1920, expected dv_o beats per line
V_ACTIVE, 1080, expected lines per frame
CNT_W, 12, width of pixel/line/frame counters (must hold H_ACTIVE and V_ACTIVE)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dv_i  in  1  stage input data valid
hs_i  in  1  stage input hsync
vs_i  in  1  stage input vsync
dv_o  in  1  stage output data valid
hs_o  in  1  stage output hsync
vs_o  in  1  stage output vsync
line_end_o  in  1  stage output line-end strobe
clr_i  in  1  clear sticky errors (one-cycle pulse)
err_o  out  5  sticky errors: [0] SYNC, [1] WIDTH, [2] HEIGHT, [3] LEND, [4] PROTO
err_any_o  out  1  OR of err_o
meas_width_o  out  CNT_W  dv_o beats counted in the last completed line
meas_height_o  out  CNT_W  lines counted in the last completed frame
frame_cnt_o  out  CNT_W  vs_o rising edges since reset, wrapping
frame_ok_o  out  1  one-cycle pulse at vs_o rise if the completed frame raised no error

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, all counters 0, delay line 0, FSM in S_FILL.
- FSM:
  - S_FILL: counts LATENCY cycles, then moves to S_SYNC.
  - S_SYNC: waits for the first vs_o rising edge, then moves to S_RUN.
  - S_RUN: steady state.
- SYNC check:
  - {dv_i,hs_i,vs_i} passes through a LATENCY-deep delay line.
  - In S_SYNC and S_RUN, any bit mismatch against {dv_o,hs_o,vs_o} sets err[0] in the next cycle.
  - No SYNC check in S_FILL.
- Width check:
  - pix_cnt increments on each dv_o=1 cycle and saturates at all ones.
  - On a dv_o falling edge (dv_o_q=1, dv_o=0): meas_width_o<=pix_cnt, pix_cnt<=0, and err[1] is set if pix_cnt≠H_ACTIVE.
  - Width is checked in S_SYNC and S_RUN.
  - The line counter increments only in S_RUN and saturates.
- LEND check: line_end_o must be 1 exactly on dv_o falling-edge cycles. It is checked in S_SYNC and S_RUN. Either a missing or a spurious line_end_o sets err[3].
- Height check:
  - On a vs_o rising edge in S_RUN: meas_height_o<=line_cnt, line_cnt<=0, and err[2] is set if line_cnt≠V_ACTIVE.
  - The first vs_o rise (S_SYNC→S_RUN) only clears line_cnt; no height check.
- PROTO check: checked in S_SYNC and S_RUN. err[4] is set if any of these holds:
  - dv_o=1 && vs_o=1
  - dv_o=1 && hs_o=1
- Frame accounting:
  - frame_cnt_o increments on every vs_o rise after S_FILL and wraps.
  - frame_ok_o pulses one cycle after a vs_o rise in S_RUN if no error event occurred since the previous vs_o rise, including that rise's height check.
  - A per-frame error flag is cleared at each vs_o rise. It is independent of clr_i.
- Sticky errors:
  - Error events OR into err_o.
  - clr_i clears err_o. If an event and clr_i occur in the same cycle, the event bit stays set.
  - err_any_o is registered together with err_o.
- Latency: every output updates one cycle after the causing input edge.
- Reset mid-frame: everything returns to S_FILL. A partial frame is never reported.

Decomposition:
- Shared package video_mon_pkg holds:
  - error bit index constants ERR_SYNC..ERR_PROTO and ERR_W=5
  - state enum {S_FILL,S_SYNC,S_RUN}
- Sub-module sync_delay_line holds the parametrised WIDTH×DEPTH shift register with async active-low reset. It is used for the 3-bit sync delay.

Test Plan:
(Params: LATENCY=2, H_ACTIVE=4, V_ACTIVE=3, CNT_W=8.)
- Clean stream: output = input delayed 2 cycles, with correct line_end_o. Run 3 frames of 3 lines × 4 beats → err_o=0, meas_width_o=4, meas_height_o=3, frame_cnt_o=3, frame_ok_o pulses at the 2nd and 3rd vs_o rise.
- Output delayed 3 cycles instead of 2 → err_o=5'b00001 after the first dv edge.
- One line with 5 beats → err[1] set, meas_width_o=5. The next frame's vs_o rise gives no frame_ok_o pulse.
- Frame with 2 lines → at vs_o rise err[2] set, meas_height_o=2.
- line_end_o asserted one cycle late → err[3] set. Then clr_i on a clean cycle → err_o=0. clr_i coinciding with a new late line_end_o → err[3] remains 1.
- vs_o high while dv_o=1 → err[4] set. Assert rst_n=0 mid-frame → all outputs 0 immediately, and no SYNC error during the following 2 S_FILL cycles.
